// File: rtl/cache_pkg.sv
// rtl/cache_pkg.sv - shared field widths and FSM state type for the data cache
// Purpose: address field widths, block width and controller state encoding
//          shared by dcache and dcache_fsm.
// Ports:   none (package).
package cache_pkg;

    localparam int TAG_W      = 3;
    localparam int INDEX_W    = 3;
    localparam int OFFSET_W   = 2;
    localparam int BLOCK_W    = 32;
    localparam int NUM_BLOCKS = 1 << INDEX_W;

    typedef enum logic [1:0] {
        S_IDLE,
        S_MEM_READ,
        S_MEM_WRITE,
        S_UPDATE
    } state_t;

endpackage

// File: rtl/dcache_fsm.sv
// rtl/dcache_fsm.sv - miss-handling controller for the data cache
// Purpose: state register and next-state/output decode for refill and
//          write-back sequencing.
// Ports:   CLK, RESET (async active-low);
//          req, hit, dirty       - CPU request and indexed line status;
//          mem_busywait          - memory stall;
//          state                 - current state (drives datapath muxes);
//          busywait, mem_read, mem_write - CPU stall and memory requests.
module dcache_fsm
    import cache_pkg::*;
(
    input  logic   CLK,
    input  logic   RESET,
    input  logic   req,
    input  logic   hit,
    input  logic   dirty,
    input  logic   mem_busywait,
    output state_t state,
    output logic   busywait,
    output logic   mem_read,
    output logic   mem_write
);

    state_t next_state;

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        busywait   = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        case (state)
            S_IDLE: begin
                // Only a miss seen here starts a transaction; a request that
                // has just been satisfied is a hit and passes through.
                if (req && !hit) begin
                    busywait   = 1'b1;
                    next_state = dirty ? S_MEM_WRITE : S_MEM_READ;
                end
            end
            S_MEM_WRITE: begin
                busywait  = 1'b1;
                mem_write = 1'b1;
                if (!mem_busywait) begin
                    next_state = S_MEM_READ;
                end
            end
            S_MEM_READ: begin
                busywait = 1'b1;
                mem_read = 1'b1;
                if (!mem_busywait) begin
                    next_state = S_UPDATE;
                end
            end
            S_UPDATE: begin
                busywait   = 1'b1;
                next_state = S_IDLE;
            end
            default: next_state = S_IDLE;
        endcase
    end

endmodule

// File: rtl/dcache.sv
// rtl/dcache.sv - direct-mapped write-back write-allocate data cache
// Purpose: byte-wide CPU responder with a 32-bit block port toward memory.
// Ports:   CLK, RESET (async active-low);
//          READ, WRITE, ADDRESS, WRITEDATA -> READDATA, BUSYWAIT (CPU side);
//          MEM_READ, MEM_WRITE, MEM_ADDRESS, MEM_WRITEDATA -> memory requests;
//          MEM_READDATA, MEM_BUSYWAIT <- memory responses.
module dcache
    import cache_pkg::*;
(
    input  logic                CLK,
    input  logic                RESET,
    input  logic                READ,
    input  logic                WRITE,
    input  logic [7:0]          ADDRESS,
    input  logic [7:0]          WRITEDATA,
    output logic [7:0]          READDATA,
    output logic                BUSYWAIT,
    output logic                MEM_READ,
    output logic                MEM_WRITE,
    output logic [5:0]          MEM_ADDRESS,
    output logic [BLOCK_W-1:0]  MEM_WRITEDATA,
    input  logic [BLOCK_W-1:0]  MEM_READDATA,
    input  logic                MEM_BUSYWAIT
);

    logic [NUM_BLOCKS-1:0] valid;
    logic [NUM_BLOCKS-1:0] dirty;
    logic [TAG_W-1:0]      tags [NUM_BLOCKS];
    logic [BLOCK_W-1:0]    data [NUM_BLOCKS];

    logic [TAG_W-1:0]      req_tag;
    logic [INDEX_W-1:0]    index;
    logic [OFFSET_W-1:0]   offset;
    logic                  hit;
    logic                  req;
    logic                  write_hit;
    logic                  fill;
    state_t                state;

    assign req_tag = ADDRESS[7:5];
    assign index   = ADDRESS[4:2];
    assign offset  = ADDRESS[1:0];
    assign hit     = valid[index] && (tags[index] == req_tag);

    // A request held through reset must not raise BUSYWAIT.
    assign req       = (READ || WRITE) && RESET;
    // READ wins when both are asserted, so only a pure WRITE stores.
    assign write_hit = (state == S_IDLE) && WRITE && !READ && hit;
    assign fill      = (state == S_UPDATE);

    dcache_fsm u_fsm (
        .CLK          (CLK),
        .RESET        (RESET),
        .req          (req),
        .hit          (hit),
        .dirty        (valid[index] && dirty[index]),
        .mem_busywait (MEM_BUSYWAIT),
        .state        (state),
        .busywait     (BUSYWAIT),
        .mem_read     (MEM_READ),
        .mem_write    (MEM_WRITE)
    );

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            valid <= '0;
            dirty <= '0;
        end else if (fill) begin
            valid[index] <= 1'b1;
            dirty[index] <= 1'b0;
        end else if (write_hit) begin
            dirty[index] <= 1'b1;
        end
    end

    // Tags and data carry no reset; valid gates every use of them.
    always_ff @(posedge CLK) begin
        if (fill) begin
            tags[index] <= req_tag;
            data[index] <= MEM_READDATA;
        end else if (write_hit) begin
            data[index][{offset, 3'b000} +: 8] <= WRITEDATA;
        end
    end

    assign READDATA = ((state == S_IDLE) && READ && hit) ?
                      data[index][{offset, 3'b000} +: 8] : 8'h00;

    always_comb begin
        MEM_ADDRESS   = '0;
        MEM_WRITEDATA = '0;
        case (state)
            S_MEM_WRITE: begin
                MEM_ADDRESS   = {tags[index], index};
                MEM_WRITEDATA = data[index];
            end
            S_MEM_READ: begin
                MEM_ADDRESS = {req_tag, index};
            end
            default: begin
                MEM_ADDRESS   = '0;
                MEM_WRITEDATA = '0;
            end
        endcase
    end

endmodule

// File: tb/tb_dcache.sv
// tb/tb_dcache.sv - self-checking bench for dcache against a line-level model
module tb_dcache;

    logic        CLK = 1'b0;
    logic        RESET = 1'b0;
    logic        READ = 1'b0;
    logic        WRITE = 1'b0;
    logic [7:0]  ADDRESS = 8'h00;
    logic [7:0]  WRITEDATA = 8'h00;
    wire  [7:0]  READDATA;
    wire         BUSYWAIT;
    wire         MEM_READ;
    wire         MEM_WRITE;
    wire  [5:0]  MEM_ADDRESS;
    wire  [31:0] MEM_WRITEDATA;
    logic [31:0] MEM_READDATA;
    wire         MEM_BUSYWAIT;

    dcache dut (
        .CLK           (CLK),
        .RESET         (RESET),
        .READ          (READ),
        .WRITE         (WRITE),
        .ADDRESS       (ADDRESS),
        .WRITEDATA     (WRITEDATA),
        .READDATA      (READDATA),
        .BUSYWAIT      (BUSYWAIT),
        .MEM_READ      (MEM_READ),
        .MEM_WRITE     (MEM_WRITE),
        .MEM_ADDRESS   (MEM_ADDRESS),
        .MEM_WRITEDATA (MEM_WRITEDATA),
        .MEM_READDATA  (MEM_READDATA),
        .MEM_BUSYWAIT  (MEM_BUSYWAIT)
    );

    always #5 CLK = ~CLK;

    int n_cmp = 0;
    int n_fail = 0;

    function automatic logic [31:0] mem_init(input int a);
        logic [31:0] v;
        v = 32'h44332211 ^ (a * 32'h9E3779B1);
        return v;
    endfunction

    // Memory responder: busy for 'lat' cycles, completes on the next edge.
    int          lat = 1;
    int          cnt = 0;
    int          n_rd = 0;
    int          n_wb = 0;
    int          err_both = 0;
    int          err_stab = 0;
    logic [31:0] mem_store [64];
    logic [63:0] mem_written = '0;
    logic [5:0]  last_rd_addr = '0;
    logic [5:0]  last_wb_addr = '0;
    logic [31:0] last_wb_data = '0;
    logic [5:0]  hold_addr = '0;

    assign MEM_BUSYWAIT = (MEM_READ || MEM_WRITE) && (cnt < lat);

    always @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            cnt <= 0;
        end else if (MEM_READ || MEM_WRITE) begin
            if (MEM_READ && MEM_WRITE) err_both <= err_both + 1;
            if (cnt > 0 && MEM_ADDRESS != hold_addr) err_stab <= err_stab + 1;
            hold_addr <= MEM_ADDRESS;
            if (cnt >= lat) begin
                cnt <= 0;
                if (MEM_WRITE) begin
                    mem_store[MEM_ADDRESS]   <= MEM_WRITEDATA;
                    mem_written[MEM_ADDRESS] <= 1'b1;
                    n_wb         <= n_wb + 1;
                    last_wb_addr <= MEM_ADDRESS;
                    last_wb_data <= MEM_WRITEDATA;
                end
                if (MEM_READ) begin
                    MEM_READDATA <= mem_written[MEM_ADDRESS] ? mem_store[MEM_ADDRESS]
                                                             : mem_init(int'(MEM_ADDRESS));
                    n_rd         <= n_rd + 1;
                    last_rd_addr <= MEM_ADDRESS;
                end
            end else begin
                cnt <= cnt + 1;
            end
        end else begin
            cnt <= 0;
        end
    end

    // Reference model: per-line state plus a full memory image.
    logic        m_valid [8];
    logic        m_dirty [8];
    logic [2:0]  m_tag   [8];
    logic [31:0] m_line  [8];
    logic [31:0] m_mem   [64];

    task automatic model_reset();
        for (int i = 0; i < 8; i++) begin
            m_valid[i] = 1'b0;
            m_dirty[i] = 1'b0;
        end
    endtask

    task automatic access(input logic rd, input logic wr, input logic [7:0] a,
                          input logic [7:0] wd, input string nm, output logic [7:0] got);
        logic [2:0]  idx;
        logic [2:0]  tg;
        logic [1:0]  off;
        int          exp_rd;
        int          exp_wb;
        int          e_stall;
        int          rd0;
        int          wb0;
        int          stall;
        bit          done;
        logic [5:0]  e_wb_addr;
        logic [5:0]  e_rd_addr;
        logic [31:0] e_wb_data;
        logic [7:0]  e_data;
        idx = a[4:2]; tg = a[7:5]; off = a[1:0];
        exp_rd = 0; exp_wb = 0; e_stall = 0; e_data = 8'h00;
        e_wb_addr = '0; e_rd_addr = '0; e_wb_data = '0;
        if (!(m_valid[idx] && m_tag[idx] == tg)) begin
            e_stall = lat + 3;
            if (m_valid[idx] && m_dirty[idx]) begin
                exp_wb    = 1;
                e_wb_addr = {m_tag[idx], idx};
                e_wb_data = m_line[idx];
                m_mem[e_wb_addr] = m_line[idx];
                e_stall += lat + 1;
            end
            exp_rd      = 1;
            e_rd_addr   = {tg, idx};
            m_line[idx] = m_mem[e_rd_addr];
            m_tag[idx]  = tg;
            m_valid[idx] = 1'b1;
            m_dirty[idx] = 1'b0;
        end
        if (rd) begin
            e_data = m_line[idx][off*8 +: 8];
        end else if (wr) begin
            m_line[idx][off*8 +: 8] = wd;
            m_dirty[idx] = 1'b1;
        end

        rd0 = n_rd; wb0 = n_wb; stall = 0; done = 0;
        @(negedge CLK);
        READ = rd; WRITE = wr; ADDRESS = a; WRITEDATA = wd;
        #1;
        for (int k = 0; k < 200 && !done; k++) begin
            if (BUSYWAIT) begin
                stall++;
                @(negedge CLK);
                #1;
            end else begin
                done = 1;
            end
        end
        got = READDATA;
        @(posedge CLK);
        #1;
        READ = 1'b0; WRITE = 1'b0;

        n_cmp++; if (!done) begin n_fail++; $display("FAIL %s timeout busywait still %b", nm, BUSYWAIT); end
        n_cmp++; if (got !== e_data) begin n_fail++; $display("FAIL %s readdata got %h exp %h", nm, got, e_data); end
        n_cmp++; if (stall != e_stall) begin n_fail++; $display("FAIL %s stall got %0d exp %0d", nm, stall, e_stall); end
        n_cmp++; if (n_rd - rd0 != exp_rd) begin n_fail++; $display("FAIL %s fetch_count got %0d exp %0d", nm, n_rd - rd0, exp_rd); end
        n_cmp++; if (n_wb - wb0 != exp_wb) begin n_fail++; $display("FAIL %s wb_count got %0d exp %0d", nm, n_wb - wb0, exp_wb); end
        if (exp_rd == 1) begin
            n_cmp++; if (last_rd_addr !== e_rd_addr) begin n_fail++; $display("FAIL %s fetch_addr got %h exp %h", nm, last_rd_addr, e_rd_addr); end
        end
        if (exp_wb == 1) begin
            n_cmp++; if (last_wb_addr !== e_wb_addr) begin n_fail++; $display("FAIL %s wb_addr got %h exp %h", nm, last_wb_addr, e_wb_addr); end
            n_cmp++; if (last_wb_data !== e_wb_data) begin n_fail++; $display("FAIL %s wb_data got %h exp %h", nm, last_wb_data, e_wb_data); end
        end
    endtask

    task automatic test_reset();
        READ = 1'b1; ADDRESS = 8'h00;
        #12;
        n_cmp++; if (BUSYWAIT !== 1'b0) begin n_fail++; $display("FAIL rst_busywait got %b exp 0", BUSYWAIT); end
        n_cmp++; if (MEM_READ !== 1'b0 || MEM_WRITE !== 1'b0) begin n_fail++; $display("FAIL rst_memreq got %b%b exp 00", MEM_READ, MEM_WRITE); end
        n_cmp++; if (MEM_ADDRESS !== 6'h00) begin n_fail++; $display("FAIL rst_memaddr got %h exp 00", MEM_ADDRESS); end
        n_cmp++; if (MEM_WRITEDATA !== 32'h0) begin n_fail++; $display("FAIL rst_memwdata got %h exp 0", MEM_WRITEDATA); end
        n_cmp++; if (READDATA !== 8'h00) begin n_fail++; $display("FAIL rst_readdata got %h exp 00", READDATA); end
        @(negedge CLK);
        READ = 1'b0;
        RESET = 1'b1;
    endtask

    task automatic test_directed();
        logic [7:0]  got;
        logic [31:0] b8;
        lat = 2;
        access(1'b1, 1'b0, 8'h00, 8'h00, "rd00_miss", got);
        n_cmp++; if (got !== 8'h11) begin n_fail++; $display("FAIL rd00 got %h exp 11", got); end
        access(1'b1, 1'b0, 8'h01, 8'h00, "rd01_hit", got);
        n_cmp++; if (got !== 8'h22) begin n_fail++; $display("FAIL rd01 got %h exp 22", got); end
        access(1'b0, 1'b1, 8'h02, 8'hAB, "wr02_hit", got);
        access(1'b1, 1'b0, 8'h02, 8'h00, "rd02_hit", got);
        n_cmp++; if (got !== 8'hAB) begin n_fail++; $display("FAIL rd02 got %h exp ab", got); end
        access(1'b1, 1'b0, 8'h22, 8'h00, "rd22_dirty", got);
        b8 = mem_init(8);
        n_cmp++; if (last_wb_data !== 32'h44AB2211) begin n_fail++; $display("FAIL rd22_wbdata got %h exp 44ab2211", last_wb_data); end
        n_cmp++; if (last_rd_addr !== 6'h08) begin n_fail++; $display("FAIL rd22_fetch got %h exp 08", last_rd_addr); end
        n_cmp++; if (got !== b8[23:16]) begin n_fail++; $display("FAIL rd22 got %h exp %h", got, b8[23:16]); end
        access(1'b0, 1'b1, 8'h45, 8'h5C, "wr45_miss", got);
        n_cmp++; if (last_rd_addr !== 6'h11) begin n_fail++; $display("FAIL wr45_fetch got %h exp 11", last_rd_addr); end
        access(1'b1, 1'b0, 8'h45, 8'h00, "rd45_hit", got);
        n_cmp++; if (got !== 8'h5C) begin n_fail++; $display("FAIL rd45 got %h exp 5c", got); end
    endtask

    task automatic test_reset_mid_read();
        logic [7:0] got;
        bit         seen;
        int         rd0;
        lat = 6; seen = 0;
        @(negedge CLK);
        READ = 1'b1; ADDRESS = 8'h60;
        for (int k = 0; k < 20 && !seen; k++) begin
            @(negedge CLK);
            #1;
            if (MEM_READ) seen = 1;
        end
        n_cmp++; if (!seen) begin n_fail++; $display("FAIL midrst_start mem_read got 0 exp 1"); end
        rd0 = n_rd;
        #2 RESET = 1'b0;
        #1;
        n_cmp++; if (MEM_READ !== 1'b0) begin n_fail++; $display("FAIL midrst_memread got %b exp 0", MEM_READ); end
        n_cmp++; if (BUSYWAIT !== 1'b0) begin n_fail++; $display("FAIL midrst_busywait got %b exp 0", BUSYWAIT); end
        n_cmp++; if (MEM_ADDRESS !== 6'h00) begin n_fail++; $display("FAIL midrst_memaddr got %h exp 00", MEM_ADDRESS); end
        READ = 1'b0;
        @(negedge CLK);
        RESET = 1'b1;
        model_reset();
        n_cmp++; if (n_rd != rd0) begin n_fail++; $display("FAIL midrst_nofetch got %0d exp %0d", n_rd, rd0); end
        lat = 1;
        access(1'b1, 1'b0, 8'h01, 8'h00, "rd01_after_rst", got);
        n_cmp++; if (got !== 8'h22) begin n_fail++; $display("FAIL rd01_after_rst got %h exp 22", got); end
    endtask

    task automatic test_random();
        logic [7:0]  got;
        logic [31:0] r;
        logic [7:0]  a;
        int          kind;
        for (int i = 0; i < 200; i++) begin
            r    = $urandom;
            a    = r[7:0];
            if (r[8]) a[7:6] = 2'b00;
            lat  = $urandom_range(0, 3);
            kind = $urandom_range(0, 3);
            case (kind)
                0, 1:    access(1'b1, 1'b0, a, r[23:16], "rand_rd", got);
                2:       access(1'b0, 1'b1, a, r[23:16], "rand_wr", got);
                default: access(1'b1, 1'b1, a, r[23:16], "rand_rdwr", got);
            endcase
        end
    endtask

    task automatic test_protocol();
        n_cmp++; if (err_both != 0) begin n_fail++; $display("FAIL both_requests got %0d exp 0", err_both); end
        n_cmp++; if (err_stab != 0) begin n_fail++; $display("FAIL addr_stable got %0d exp 0", err_stab); end
    endtask

    initial begin
        for (int i = 0; i < 64; i++) m_mem[i] = mem_init(i);
        model_reset();
        test_reset();
        test_directed();
        test_reset_mid_read();
        test_random();
        test_protocol();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1);
    end

endmodule

// File: doc/dcache.md
# dcache

Direct-mapped, write-back, write-allocate data cache that sits between `cpu` and the word-wide data memory. It is the responder for the CPU's byte-wide READ/WRITE/BUSYWAIT memory protocol. It also acts as the initiator toward data memory on a 32-bit block-wide port. Hits complete without stalling the CPU; misses stall the CPU through BUSYWAIT while the block is refilled and, if dirty, first written back.

## Interface
- `NUM_BLOCKS`, 8: cache lines; index width = log2(NUM_BLOCKS) = 3.
- `TAG_W`, 3: tag bits; ADDRESS = {tag[7:5], index[4:2], offset[1:0]}.
- `CLK` in 1: single clock; all state updates on posedge.
- `RESET` in 1: asynchronous, active-low reset.
- `READ` in 1: CPU byte read request, held until BUSYWAIT falls.
- `WRITE` in 1: CPU byte write request, held until BUSYWAIT falls.
- `ADDRESS` in 8: CPU byte address.
- `WRITEDATA` in 8: CPU write byte.
- `READDATA` out 8: selected byte on a read hit.
- `BUSYWAIT` out 1: CPU stall.
- `MEM_READ` out 1: block fetch request.
- `MEM_WRITE` out 1: block write-back request.
- `MEM_ADDRESS` out 6: block address {tag, index}.
- `MEM_WRITEDATA` out 32: victim block, byte 0 in [7:0].
- `MEM_READDATA` in 32: fetched block, byte 0 in [7:0].
- `MEM_BUSYWAIT` in 1: memory stall; high from the cycle a request appears until data/ack is ready.

## Operation
- Per line: valid bit, dirty bit, TAG_W tag, 32-bit data.
- Hit = valid[index] && tag[index] == ADDRESS tag; evaluated combinationally.
- READ and WRITE both high: treated as READ; WRITEDATA ignored.
- FSM states:
  - IDLE
    - No request: BUSYWAIT=0.
    - Request + hit: BUSYWAIT=0. Read returns byte[offset]. Write stores WRITEDATA into byte[offset] and sets dirty at the next posedge.
    - Request + miss + clean: BUSYWAIT=1 and go to MEM_READ.
    - Request + miss + dirty: BUSYWAIT=1 and go to MEM_WRITE.
  - MEM_WRITE
    - MEM_WRITE=1.
    - MEM_ADDRESS = {stored tag, index}; MEM_WRITEDATA = line data.
    - At the first posedge with MEM_BUSYWAIT=0, go to MEM_READ.
  - MEM_READ
    - MEM_READ=1, MEM_ADDRESS = {request tag, index}.
    - At the first posedge with MEM_BUSYWAIT=0, go to UPDATE.
  - UPDATE
    - Memory request lines low.
    - At posedge: line ← MEM_READDATA, tag ← request tag, valid=1, dirty=0; go to IDLE.
    - The request then re-evaluates as a hit, and a pending write is merged as a normal write hit.
- BUSYWAIT is 1 in MEM_WRITE, MEM_READ and UPDATE.
- MEM_READ and MEM_WRITE are never high together.
- Only one memory request is outstanding at a time.
- READDATA is 8'h00 when there is no read hit.

## Timing
- Reset (asserted low, async), cleared immediately regardless of state:
  - all valid and dirty bits cleared; FSM → IDLE;
  - BUSYWAIT, MEM_READ, MEM_WRITE = 0;
  - MEM_ADDRESS = 0, MEM_WRITEDATA = 0, READDATA = 0.
- Data array contents are not reset.
- Reset during MEM_READ/MEM_WRITE: the request is abandoned; no line is updated.
- Read hit: READDATA is valid the same cycle and BUSYWAIT stays 0, so zero stall cycles.
- Write hit: data is committed at the next posedge; zero stall cycles.
- Clean miss: stall = 1 (IDLE→MEM_READ) + memory latency + 1 (UPDATE) cycles.
- Dirty miss: the clean-miss stall plus the write-back memory latency.
- Request lines are held stable for the whole memory transaction.
- CPU READ/WRITE drop after BUSYWAIT falls. The cache must not start a new transaction on a request that is already satisfied: IDLE hit evaluation only.
- Index wrap: addresses 0x00 and 0x20 map to the same line (index 0) and evict each other.

## Structure
- Shared package `cache_pkg`:
  - FSM state enum (IDLE, MEM_READ, MEM_WRITE, UPDATE);
  - field widths TAG_W / INDEX_W / OFFSET_W = 3 / 3 / 2;
  - block width = 32.
- One sub-module, `dcache_fsm`: state register plus next-state/output decode.
- Arrays and hit logic live in `dcache`.

## Test plan
- Reset, READ 0x00 (memory returns 0x44332211):
  - one MEM_READ with MEM_ADDRESS 6'h00;
  - BUSYWAIT falls after UPDATE; READDATA = 0x11.
- Then READ 0x01: hit, BUSYWAIT never rises, READDATA = 0x22.
- WRITE 0x02 data 0xAB (hit): no MEM_* activity; READ 0x02 then returns 0xAB.
- READ 0x22 after the above:
  - MEM_WRITE with MEM_ADDRESS 6'h00, MEM_WRITEDATA 0x44AB2211;
  - then MEM_READ with MEM_ADDRESS 6'h08; READDATA = byte 2 of the fetched block.
- WRITE miss to 0x45 data 0x5C on a clean line: MEM_READ of 6'h11, then merge; READ 0x45 → 0x5C with no memory access.
- RESET pulsed low mid-MEM_READ:
  - MEM_READ and BUSYWAIT drop immediately;
  - after release, READ 0x01 misses (line invalid).
